// File: rtl/data_memory_pkg.sv
// Shared memory geometry for the datapath, the ALU result-to-address path and the data memory.
package data_memory_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, registered read-first read,
// asynchronous active-high reset that clears both the array and the read register.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Next read value: sample the addressed word on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (memRead) begin
      rdata_d = mem_q[address];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage and output register; the read sees the pre-edge word, so a same-address write is read-first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i[ADDR_W-1:0]] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (memWrite) begin
        mem_q[address] <= data_in;
      end
      rdata_q <= rdata_d;
    end
  end

  assign data_out = rdata_q;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed plus randomized checks of data_memory against an array-based reference model.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [9:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;

  logic [31:0] ref_mem [1024];
  logic [31:0] ref_out;
  int          tests;
  int          failed;

  data_memory dut (
    .clk      (clk),
    .reset    (reset),
    .memRead  (memRead),
    .memWrite (memWrite),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = 32'd0;
    ref_out = 32'd0;
  endtask

  // One clock of stimulus; the model applies the read before the write (read-first).
  task automatic step(input string tag, input logic rd, input logic wr,
                      input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    memRead  = rd;
    memWrite = wr;
    address  = a;
    data_in  = d;
    @(posedge clk);
    if (rd) ref_out = ref_mem[a];
    if (wr) ref_mem[a] = d;
    #1;
    check(tag, data_out, ref_out);
  endtask

  initial begin
    logic [31:0] v;
    tests    = 0;
    failed   = 0;
    reset    = 1'b1;
    memRead  = 1'b0;
    memWrite = 1'b0;
    address  = 10'd0;
    data_in  = 32'd0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_initial", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Make data_out non-zero, then pulse reset for one cycle.
    v = $urandom | 32'd1;
    step("pre_wr9", 1'b0, 1'b1, 10'd9, v);
    step("pre_rd9", 1'b1, 1'b0, 10'd9, 32'd0);
    check("pre_rd9_val", data_out, v);
    step("idle", 1'b0, 1'b0, 10'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("reset_pulse", data_out, 32'd0);
    reset = 1'b0;
    step("rd9_after_rst", 1'b1, 1'b0, 10'd9, 32'd0);
    check("rd9_zero", data_out, 32'd0);
    step("rd1023_after_rst", 1'b1, 1'b0, 10'd1023, 32'd0);
    check("rd1023_zero", data_out, 32'd0);

    // Write then read; data_in changes during the read but must not be stored.
    step("wr9_748", 1'b0, 1'b1, 10'd9, 32'd748);
    step("rd9", 1'b1, 1'b0, 10'd9, 32'd543);
    check("rd9_748", data_out, 32'd748);

    // Hold: data_out stays while memRead is low.
    for (int k = 0; k < 3; k++) begin
      step("hold_step", 1'b0, 1'b0, 10'($urandom_range(0, 1023)), $urandom);
      check("hold_748", data_out, 32'd748);
    end

    step("wr0_2", 1'b0, 1'b1, 10'd0, 32'd2);
    step("rd0", 1'b1, 1'b0, 10'd0, 32'd0);
    check("rd0_2", data_out, 32'd2);
    step("rd9_again", 1'b1, 1'b0, 10'd9, 32'd0);
    check("rd9_still_748", data_out, 32'd748);

    // Same-edge read and write of one address returns the old word.
    step("wr5_10", 1'b0, 1'b1, 10'd5, 32'd10);
    step("rw5", 1'b1, 1'b1, 10'd5, 32'd20);
    check("rw5_old", data_out, 32'd10);
    step("rd5", 1'b1, 1'b0, 10'd5, 32'd0);
    check("rd5_new", data_out, 32'd20);

    step("wr1023", 1'b0, 1'b1, 10'd1023, 32'hCAFE_F00D);
    step("rd1023", 1'b1, 1'b0, 10'd1023, 32'd0);
    check("rd1023_val", data_out, 32'hCAFE_F00D);

    // Randomized traffic, biased to a few hot addresses plus the top word.
    for (int k = 0; k < 300; k++) begin
      logic [9:0] a;
      case ($urandom_range(0, 3))
        0:       a = 10'd1023;
        1:       a = 10'($urandom_range(0, 1023));
        default: a = 10'($urandom_range(0, 7));
      endcase
      step("rand", 1'($urandom), 1'($urandom), a, $urandom);
    end

    // Asynchronous reset between edges while a write to 1023 is pending.
    step("pre_async_wr", 1'b0, 1'b1, 10'd3, 32'h1234_5678);
    step("pre_async_rd", 1'b1, 1'b0, 10'd3, 32'd0);
    check("pre_async_val", data_out, 32'h1234_5678);
    @(negedge clk);
    memRead  = 1'b1;
    memWrite = 1'b1;
    address  = 10'd1023;
    data_in  = 32'hDEAD_BEEF;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_out", data_out, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    memWrite = 1'b0;
    memRead  = 1'b0;
    step("rd1023_post", 1'b1, 1'b0, 10'd1023, 32'd0);
    check("rd1023_post_zero", data_out, 32'd0);
    step("rd3_post", 1'b1, 1'b0, 10'd3, 32'd0);
    check("rd3_post_zero", data_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_data_memory
